// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM.
// Sequences fetch/decode/execute/memory/writeback over a single shared
// instruction/data memory port, counts retired instructions and parks in
// TRAP on illegal opcodes, SYSTEM instructions or a stalled memory access.
//
// state     | meaning
// ----------+------------------------------------------------------------
// BOOT      | first cycle after reset, nothing asserted
// FETCH     | request instruction at PC, load IR on ready
// DECODE    | classify opcode, trap on SYSTEM or unknown opcodes
// EXECUTE   | ALU operand select; branches resolve and retire here
// MEM       | load/store data access at ALU result address
// WRITEBACK | register file write and PC update, retire
// TRAP      | halted until reset, trap_cause held
module rv32i_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_instr,
  output logic             ir_we,
  output logic             dr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'b10;
  localparam logic [1:0] CAUSE_BUS     = 2'b11;

  // The last waiting cycle allowed: trap fires when this many cycles have
  // already been waited and ready is still low.
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic       is_op, is_op_imm, is_load, is_store, is_branch;
  logic       is_jal, is_jalr, is_lui, is_auipc, is_system, is_legal;
  logic       to_expired;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign unused_instr_bits = ^instr[31:12];

  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_legal  = is_op | is_op_imm | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  assign to_expired = (to_cnt_q >= TO_LAST);

  // State, timeout counter, trap cause and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      cause_q   <= 2'b00;
      to_cnt_q  <= 16'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      to_cnt_q  <= to_cnt_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and datapath controls from state, opcode and mem_ready.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    to_cnt_d  = 16'd0;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_instr = 1'b0;
    ir_we     = 1'b0;
    dr_we     = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = 2'b00;
    halted    = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req   = 1'b1;
        mem_instr = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (to_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end

      S_DECODE: begin
        if (is_system) begin
          state_d = S_TRAP;
          cause_d = CAUSE_SYSTEM;
        end else if (!is_legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        alu_a_sel = is_auipc;
        alu_b_sel = !(is_op || is_branch);
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            dr_we   = 1'b1;
            state_d = S_WRITEBACK;
          end
        end else if (to_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end

      S_WRITEBACK: begin
        rf_we = (rd != 5'd0);
        if (is_load)                wb_sel = 2'b01;
        else if (is_jal || is_jalr) wb_sel = 2'b10;
        else if (is_lui)            wb_sel = 2'b11;
        else                        wb_sel = 2'b00;
        pc_we = 1'b1;
        if (is_jal)       pc_sel = 2'b01;
        else if (is_jalr) pc_sel = 2'b10;
        else              pc_sel = 2'b00;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign instret_d  = instret_q + (retire ? CNT_W'(1) : CNT_W'(0));
  assign instret    = instret_q;
  assign trap_cause = cause_q;

endmodule
